fpf_grant_scheduler: RTL and testbench



---
 rtl/fpf_pkg.sv | 23 ++
 rtl/fpf_rr_pick.sv | 48 ++++
 rtl/fpf_grant_scheduler.sv | 151 +++++++++++++++
 tb/tb_fpf_grant_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpf_pkg.sv
// ============================================================================
// fpf_pkg : shared types and helpers for the flattened-priority grant path
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_OFFER = 2'd2,
    ST_HOLD  = 2'd3
  } fpf_state_e;

  // Index width that never collapses to zero bits for a single entry.
  function automatic int fpf_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpf_rr_pick.sv
// ============================================================================
// fpf_rr_pick : combinational round-robin pick of one request at/after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpf_rr_pick
  import fpf_pkg::*;
#(
  parameter int N = 24,
  localparam int IW = fpf_clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam int PW = fpf_clog2(2 * N);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [PW-1:0]  pos;

  // Lower half holds only requests at/after ptr, so the lowest set bit of the
  // doubled vector is the wrapped round-robin winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr_i);
    end
    dbl = {req_i, req_i & mask};
    pos = '0;
    for (int k = 2 * N - 1; k >= 0; k--) begin
      if (dbl[k]) pos = PW'(k);
    end
    any_o   = |req_i;
    idx_o   = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      grant_o[i] = any_o && (idx_o == IW'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpf_grant_scheduler.sv
// ============================================================================
// fpf_grant_scheduler : level-first, round-robin grant with valid/ready offer
// and hold-until-release. Optional macro FPF_GRANT_INREG_EN adds an input
// pipeline register ahead of the capture stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpf_grant_scheduler
  import fpf_pkg::*;
#(
  parameter int N = 24,
  parameter int P = 8,
  localparam int IW = fpf_clog2(N),
  localparam int LW = fpf_clog2(P)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N*P-1:0]  i_p_r,
  input  logic            i_p_r_valid,
  output logic            o_p_r_ready,
  output logic            o_grant_valid,
  output logic [N-1:0]    o_grant,
  output logic [IW-1:0]   o_grant_idx,
  output logic [LW-1:0]   o_grant_level,
  input  logic            i_grant_ready,
  input  logic            i_release,
  output logic            o_busy
);

  fpf_state_e             state_q, state_d;
  logic [N*P-1:0]         req_q, req_d;
  logic [P-1:0][IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N-1:0]           grant_q, grant_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [LW-1:0]          level_q, level_d;

  logic [N*P-1:0]         cap_req;
  logic                   cap_valid;
  logic [LW-1:0]          sel_lvl;
  logic [N-1:0]           sel_req;
  logic [N-1:0]           pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;

`ifdef FPF_GRANT_INREG_EN
  logic [N*P-1:0] in_req_q;
  logic           in_valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_req_q   <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_req_q   <= i_p_r;
      in_valid_q <= i_p_r_valid;
    end
  end

  assign cap_req   = in_req_q;
  assign cap_valid = in_valid_q;
`else
  assign cap_req   = i_p_r;
  assign cap_valid = i_p_r_valid;
`endif

  always_comb begin
    sel_lvl = '0;
    for (int j = 0; j < P; j++) begin
      if (|req_q[j*N +: N]) sel_lvl = LW'(j);
    end
    sel_req = req_q[int'(sel_lvl)*N +: N];
  end

  fpf_rr_pick #(.N(N)) u_pick (
    .req_i   (sel_req),
    .ptr_i   (rr_ptr_q[sel_lvl]),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      idx_q    <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      level_q  <= level_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    level_d  = level_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_valid) begin
          req_d   = cap_req;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!pick_any) begin
          state_d = ST_IDLE;
        end else begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          level_d = sel_lvl;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // Release here is deliberately ignored; only the handshake advances.
        if (i_grant_ready) begin
          rr_ptr_d[level_q] = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_release) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_p_r_ready   = (state_q == ST_IDLE);
  assign o_grant_valid = (state_q == ST_OFFER);
  assign o_busy        = (state_q == ST_HOLD);
  assign o_grant       = grant_q;
  assign o_grant_idx   = idx_q;
  assign o_grant_level = level_q;

endmodule

`default_nettype wire

// File: tb/tb_fpf_grant_scheduler.sv
// ============================================================================
// tb_fpf_grant_scheduler : directed and random transactions vs a winner model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpf_grant_scheduler;

  localparam int N  = 24;
  localparam int P  = 8;
  localparam int IW = 5;
  localparam int LW = 3;

  logic           clk;
  logic           rst_n;
  logic [N*P-1:0] i_p_r;
  logic           i_p_r_valid;
  logic           o_p_r_ready;
  logic           o_grant_valid;
  logic [N-1:0]   o_grant;
  logic [IW-1:0]  o_grant_idx;
  logic [LW-1:0]  o_grant_level;
  logic           i_grant_ready;
  logic           i_release;
  logic           o_busy;

  int total = 0;
  int bad   = 0;
  int m_ptr [P];

  fpf_grant_scheduler #(.N(N), .P(P)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_p_r         (i_p_r),
    .i_p_r_valid   (i_p_r_valid),
    .o_p_r_ready   (o_p_r_ready),
    .o_grant_valid (o_grant_valid),
    .o_grant       (o_grant),
    .o_grant_idx   (o_grant_idx),
    .o_grant_level (o_grant_level),
    .i_grant_ready (i_grant_ready),
    .i_release     (i_release),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner = highest non-empty level, then first requester at/after that
  // level's pointer going upward with wrap.
  task automatic model_pick(input logic [N*P-1:0] v, output int lvl, output int idx);
    lvl = -1;
    idx = -1;
    for (int j = 0; j < P; j++)
      for (int i = 0; i < N; i++)
        if (v[j*N+i]) lvl = j;
    if (lvl >= 0)
      for (int k = N - 1; k >= 0; k--) begin
        int i;
        i = (m_ptr[lvl] + k) % N;
        if (v[lvl*N+i]) idx = i;
      end
  endtask

  function automatic logic [N*P-1:0] rand_vec(input int nbits, input int lvl_fix);
    logic [N*P-1:0] v;
    v = '0;
    for (int b = 0; b < nbits; b++) begin
      int j;
      j = (lvl_fix >= 0) ? lvl_fix : int'($urandom_range(P - 1));
      v[j*N + int'($urandom_range(N - 1))] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < P; j++) m_ptr[j] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, o_p_r_ready, 1);
    check({tag, "_valid"}, o_grant_valid, 0);
    check({tag, "_grant"}, o_grant, 0);
    check({tag, "_idx"}, o_grant_idx, 0);
    check({tag, "_level"}, o_grant_level, 0);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  task automatic do_txn(input logic [N*P-1:0] vec, input int rdy_delay,
                        input int rel_delay, output int dut_idx);
    int lvl, idx, guard;
    logic [63:0] exp_grant;
    dut_idx = -1;
    guard = 0;
    while (!o_p_r_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!o_p_r_ready) check("ready_timeout", o_p_r_ready, 1);
    model_pick(vec, lvl, idx);
    i_p_r = vec;
    i_p_r_valid = 1'b1;
    tick();
    i_p_r_valid = 1'b0;
    i_p_r = rand_vec(3, -1);
`ifdef FPF_GRANT_INREG_EN
    tick();
`endif
    check("arb_valid", o_grant_valid, 0);
    check("arb_ready", o_p_r_ready, 0);
    tick();
    if (lvl < 0) begin
      check("empty_valid", o_grant_valid, 0);
      check("empty_back_idle", o_p_r_ready, 1);
      return;
    end
    exp_grant = 64'(1) << idx;
    dut_idx = int'(o_grant_idx);
    check("offer_valid", o_grant_valid, 1);
    check("offer_idx", o_grant_idx, idx);
    check("offer_level", o_grant_level, lvl);
    check("offer_grant", o_grant, exp_grant);
    check("offer_busy", o_busy, 0);
    for (int k = 0; k < rdy_delay; k++) begin
      i_release = (k % 2 == 0) ? 1'b1 : 1'($urandom_range(1));
      tick();
      i_release = 1'b0;
      check("wait_valid", o_grant_valid, 1);
      check("wait_idx", o_grant_idx, idx);
      check("wait_grant", o_grant, exp_grant);
      check("wait_ready", o_p_r_ready, 0);
    end
    i_grant_ready = 1'b1;
    i_release = 1'($urandom_range(1));
    tick();
    i_grant_ready = 1'b0;
    i_release = 1'b0;
    m_ptr[lvl] = (idx == N - 1) ? 0 : idx + 1;
    check("hold_busy", o_busy, 1);
    check("hold_valid", o_grant_valid, 0);
    check("hold_grant", o_grant, exp_grant);
    check("hold_idx", o_grant_idx, idx);
    check("hold_level", o_grant_level, lvl);
    check("hold_ready", o_p_r_ready, 0);
    for (int k = 0; k < rel_delay; k++) begin
      tick();
      check("hold_wait_busy", o_busy, 1);
      check("hold_wait_ready", o_p_r_ready, 0);
    end
    i_release = 1'b1;
    tick();
    i_release = 1'b0;
    check("rel_busy", o_busy, 0);
    check("rel_grant", o_grant, 0);
    check("rel_ready", o_p_r_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [N*P-1:0] v;
    int got;
    int rr_exp [4];
    rr_exp = '{2, 7, 2, 7};

    rst_n = 1'b0;
    i_p_r = '0;
    i_p_r_valid = 1'b0;
    i_grant_ready = 1'b0;
    i_release = 1'b0;
    model_reset();
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check_reset_outputs("idle");

    // Level priority: level 6 beats level 3.
    v = '0;
    v[3*N+5] = 1'b1;
    v[6*N+9] = 1'b1;
    do_txn(v, 0, 0, got);
    check("prio_idx", got, 9);

    // Round robin at level 0 between inputs 2 and 7.
    v = '0;
    v[2] = 1'b1;
    v[7] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      do_txn(v, 0, 1, got);
      check("rr_seq", got, rr_exp[r]);
    end

    // Wrap at level 7: prime pointer to 22, then 22 wins, then 0 wins.
    v = '0;
    v[7*N+21] = 1'b1;
    do_txn(v, 0, 0, got);
    v = '0;
    v[7*N+22] = 1'b1;
    v[7*N+0]  = 1'b1;
    do_txn(v, 1, 0, got);
    check("wrap_first", got, 22);
    do_txn(v, 0, 0, got);
    check("wrap_second", got, 0);

    // Empty vector returns to idle without a grant.
    do_txn('0, 0, 0, got);
    check("empty_no_grant", o_grant, 0);

    // Long stall in OFFER with release pulses, then a long hold.
    v = '0;
    v[5*N+13] = 1'b1;
    v[1*N+3]  = 1'b1;
    do_txn(v, 5, 4, got);
    check("stall_idx", got, 13);

    // Asynchronous reset while a grant is offered.
    v = '0;
    v[4*N+11] = 1'b1;
    i_p_r = v;
    i_p_r_valid = 1'b1;
    tick();
    i_p_r_valid = 1'b0;
`ifdef FPF_GRANT_INREG_EN
    tick();
`endif
    tick();
    check("pre_rst_valid", o_grant_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      int mode;
      mode = int'($urandom_range(9));
      if (mode == 0)      v = '0;
      else if (mode < 4)  v = rand_vec(int'($urandom_range(4, 1)), int'($urandom_range(P - 1)));
      else                v = rand_vec(int'($urandom_range(5, 1)), -1);
      do_txn(v, int'($urandom_range(3)), int'($urandom_range(3)), got);
      if (($urandom_range(3)) == 0) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
